sd_serial_parallel: RTL and testbench

Receive-side deserializer of the SD command/response path; the counterpart of the transmit serializer. It waits for a start bit on the serial line, shifts in one full 48-bit SD frame MSB-first on iSD_clock, checks the end bit and CRC7, and presents the frame as a parallel word with a one-cycle completion strobe. It sits between the SD CMD line (or the serializer output in loopback benches) and the control logic that decodes responses.

---
 rtl/sd_serial_parallel.sv | 157 +++++++++++++++
 tb/tb_sd_serial_parallel.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_serial_parallel.sv
`timescale 1ns/1ps
// sd_serial_parallel
//   Receive-side deserializer for the SD command/response line. It waits for
//   a start bit, shifts in one frame MSB-first, checks the end bit and CRC7,
//   and presents the frame in parallel with a one-cycle completion strobe.
//
//   iSD_clock  in   sole clock, rising edge
//   iReset     in   asynchronous, active-high reset
//   iEnable    in   arm request, only looked at in IDLE
//   iSerial    in   serial data line, idles high
//   oParallel  out  last received frame, MSB = start bit
//   oComplete  out  one-cycle strobe when oParallel updates
//   oError     out  last frame had a bad end bit or CRC mismatch
//   oTimeout   out  one-cycle strobe when no start bit arrived in time
//   oBusy      out  high while waiting for a start bit or receiving
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | disarmed; the serial line is ignored
//   WAIT_START | armed; counting high samples until a start bit or timeout
//   RECEIVE    | shifting in the remaining frame bits
module sd_serial_parallel #(
  parameter int FRAME_WIDTH = 48,
  parameter int TIMEOUT     = 64,
  parameter bit CRC_CHECK   = 1'b1
) (
  input  logic                   iSD_clock,
  input  logic                   iReset,
  input  logic                   iEnable,
  input  logic                   iSerial,
  output logic [FRAME_WIDTH-1:0] oParallel,
  output logic                   oComplete,
  output logic                   oError,
  output logic                   oTimeout,
  output logic                   oBusy
);

  localparam int BIT_W  = $clog2(FRAME_WIDTH);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_WIDTH - 1);
  // CRC covers everything above the 7-bit CRC field and the end bit.
  localparam logic [BIT_W-1:0]  CRC_END   = BIT_W'(FRAME_WIDTH - 8);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE
  } stateT;

  stateT state, stateNext;

  // The top bit of a frame is only needed at completion, so the shift
  // register holds one bit less and the incoming bit completes the word.
  logic [FRAME_WIDTH-2:0] shiftReg, shiftNext;
  logic [BIT_W-1:0]       bitCnt, bitCntNext;
  logic [WAIT_W-1:0]      waitCnt, waitCntNext;
  logic [6:0]             crcReg, crcNext;
  logic [FRAME_WIDTH-1:0] parallelNext;
  logic                   completeNext;
  logic                   errorNext;
  logic                   timeoutNext;
  logic [FRAME_WIDTH-1:0] frameNow;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign frameNow = {shiftReg, iSerial};

  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    bitCntNext   = bitCnt;
    waitCntNext  = waitCnt;
    crcNext      = crcReg;
    parallelNext = oParallel;
    completeNext = 1'b0;
    errorNext    = oError;
    timeoutNext  = 1'b0;

    unique case (state)
      IDLE: begin
        if (iEnable) begin
          stateNext   = WAIT_START;
          waitCntNext = '0;
          errorNext   = 1'b0;
        end
      end

      WAIT_START: begin
        // A start bit is checked before the timeout so it wins on the last sample.
        if (!iSerial) begin
          stateNext  = RECEIVE;
          shiftNext  = frameNow[FRAME_WIDTH-2:0];
          bitCntNext = BIT_W'(1);
          crcNext    = crc7Step(7'd0, iSerial);
        end else if (waitCnt == WAIT_LAST) begin
          stateNext   = IDLE;
          timeoutNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end

      RECEIVE: begin
        shiftNext = frameNow[FRAME_WIDTH-2:0];
        if (bitCnt < CRC_END) begin
          crcNext = crc7Step(crcReg, iSerial);
        end
        if (bitCnt == LAST_BIT) begin
          // crcReg already covers every CRC'd bit by the time the end bit arrives.
          stateNext    = IDLE;
          bitCntNext   = '0;
          parallelNext = frameNow;
          completeNext = 1'b1;
          errorNext    = ~iSerial | (CRC_CHECK && (crcReg != frameNow[7:1]));
        end else begin
          bitCntNext = bitCnt + 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iSD_clock or posedge iReset) begin
    if (iReset) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitCnt    <= '0;
      waitCnt   <= '0;
      crcReg    <= '0;
      oParallel <= '0;
      oComplete <= 1'b0;
      oError    <= 1'b0;
      oTimeout  <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      state     <= stateNext;
      shiftReg  <= shiftNext;
      bitCnt    <= bitCntNext;
      waitCnt   <= waitCntNext;
      crcReg    <= crcNext;
      oParallel <= parallelNext;
      oComplete <= completeNext;
      oError    <= errorNext;
      oTimeout  <= timeoutNext;
      oBusy     <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_sd_serial_parallel.sv
`timescale 1ns/1ps
module tb_sd_serial_parallel;

  localparam int FW = 48;
  localparam int TO = 64;

  localparam logic [FW-1:0] F_CMD0    = 48'h400000000095;
  localparam logic [FW-1:0] F_CMD8    = 48'h48000001AA87;
  localparam logic [FW-1:0] F_BADCRC  = 48'h400000000097;
  localparam logic [FW-1:0] F_BADEND  = 48'h400000000094;

  logic clk = 1'b0;
  logic iReset, iEnable, iSerial;
  logic [FW-1:0] par1, par2;
  logic cmp1, cmp2, err1, err2, to1, to2, busy1, busy2;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            isTimeout;
    logic [FW-1:0] data;
    bit            err;
    int unsigned   cyc;
  } expT;

  expT q1[$];
  expT q2[$];

  sd_serial_parallel #(.FRAME_WIDTH(FW), .TIMEOUT(TO), .CRC_CHECK(1'b1)) dut1 (
    .iSD_clock(clk), .iReset(iReset), .iEnable(iEnable), .iSerial(iSerial),
    .oParallel(par1), .oComplete(cmp1), .oError(err1), .oTimeout(to1), .oBusy(busy1)
  );

  sd_serial_parallel #(.FRAME_WIDTH(FW), .TIMEOUT(TO), .CRC_CHECK(1'b0)) dut2 (
    .iSD_clock(clk), .iReset(iReset), .iEnable(iEnable), .iSerial(iSerial),
    .oParallel(par2), .oComplete(cmp2), .oError(err2), .oTimeout(to2), .oBusy(busy2)
  );

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expectEvent(input bit isTo, input logic [FW-1:0] d, input bit e1, input bit e2,
                             input int unsigned c);
    expT e;
    e.isTimeout = isTo;
    e.data      = d;
    e.cyc       = c;
    e.err       = e1;
    q1.push_back(e);
    e.err       = e2;
    q2.push_back(e);
  endtask

  task automatic monitorEvent(input int id, input logic comp, input logic to,
                              input logic [FW-1:0] par, input logic err);
    expT e;
    bit empty;
    bit bad;
    checks++;
    empty = (id == 1) ? (q1.size() == 0) : (q2.size() == 0);
    if (empty) begin
      errors++;
      $display("FAIL dut%0d unexpected event: complete=%b timeout=%b parallel=%h cycle=%0d, expected no event",
               id, comp, to, par, cyc);
    end else begin
      if (id == 1) e = q1.pop_front();
      else         e = q2.pop_front();
      bad = ({comp, to} !== (e.isTimeout ? 2'b01 : 2'b10)) || (cyc != e.cyc);
      if (!e.isTimeout && ((par !== e.data) || (err !== e.err))) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL dut%0d event: complete=%b timeout=%b parallel=%h error=%b cycle=%0d, expected timeout=%b parallel=%h error=%b cycle=%0d",
                 id, comp, to, par, err, cyc, e.isTimeout, e.data, e.err, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp1 || to1) monitorEvent(1, cmp1, to1, par1, err1);
    if (cmp2 || to2) monitorEvent(2, cmp2, to2, par2, err2);
  end

  task automatic tick(input int n, input logic s);
    repeat (n) begin
      @(negedge clk);
      iSerial = s;
    end
  endtask

  // Returns at the negedge following the arming edge.
  task automatic arm(input bit hold);
    @(negedge clk);
    iEnable = 1'b1;
    iSerial = 1'b1;
    @(negedge clk);
    if (!hold) iEnable = 1'b0;
  endtask

  task automatic sendFrame(input logic [FW-1:0] f, input bit e1, input bit e2,
                           input int nbits, input bit push);
    for (int i = FW - 1; i >= FW - nbits; i--) begin
      @(negedge clk);
      // start bit sampled at edge cyc+1, completion seen at the negedge after edge cyc+FW
      if (i == FW - 1 && push) expectEvent(1'b0, f, e1, e2, cyc + FW);
      iSerial = f[i];
    end
  endtask

  task automatic endFrame();
    @(negedge clk);
    iSerial = 1'b1;
    iEnable = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rnd;
    logic [39:0] hi;
    logic [FW-1:0] f;

    iReset  = 1'b1;
    iEnable = 1'b0;
    iSerial = 1'b1;
    repeat (3) @(negedge clk);
    iReset = 1'b0;
    @(negedge clk);
    checkEq("reset oParallel", 64'(par1), 64'(0));
    checkEq("reset flags", 64'({cmp1, err1, to1, busy1}), 64'(0));

    // low line in IDLE must be ignored
    tick(5, 1'b0);
    checkEq("idle low busy", 64'(busy1), 64'(0));
    tick(3, 1'b1);

    // single valid frame
    arm(1'b0);
    checkEq("armed busy", 64'(busy1), 64'(1));
    tick(3, 1'b1);
    sendFrame(F_CMD0, 1'b0, 1'b0, FW, 1'b1);
    endFrame();
    tick(3, 1'b1);
    checkEq("post frame busy", 64'(busy1), 64'(0));

    // back-to-back frames with iEnable held
    arm(1'b1);
    tick(2, 1'b1);
    sendFrame(F_CMD0, 1'b0, 1'b0, FW, 1'b1);
    tick(1, 1'b1);
    sendFrame(F_CMD8, 1'b0, 1'b0, FW, 1'b1);
    endFrame();
    tick(3, 1'b1);
    checkEq("b2b last oParallel", 64'(par1), 64'(F_CMD8));

    // CRC error; dut2 ignores CRC
    arm(1'b0);
    tick(2, 1'b1);
    sendFrame(F_BADCRC, 1'b1, 1'b0, FW, 1'b1);
    endFrame();
    tick(3, 1'b1);
    checkEq("oError holds", 64'(err1), 64'(1));
    arm(1'b0);
    checkEq("oError cleared on arm", 64'(err1), 64'(0));
    tick(2, 1'b1);
    sendFrame(F_BADEND, 1'b1, 1'b1, FW, 1'b1);
    endFrame();
    tick(3, 1'b1);

    // timeout with line held high
    arm(1'b0);
    expectEvent(1'b1, '0, 1'b0, 1'b0, cyc + TO);
    tick(TO - 1, 1'b1);
    checkEq("busy before timeout", 64'(busy1), 64'(1));
    tick(2, 1'b1);
    checkEq("busy after timeout", 64'(busy1), 64'(0));
    tick(2, 1'b1);

    // start bit exactly on the last allowed sample
    arm(1'b0);
    tick(TO - 2, 1'b1);
    sendFrame(F_CMD8, 1'b0, 1'b0, FW, 1'b1);
    endFrame();
    tick(3, 1'b1);

    // reset in the middle of a frame
    arm(1'b0);
    tick(2, 1'b1);
    sendFrame(F_CMD0, 1'b0, 1'b0, 20, 1'b0);
    @(posedge clk);
    #2 iReset = 1'b1;
    #1;
    checkEq("midframe reset oParallel", 64'(par1), 64'(0));
    checkEq("midframe reset flags", 64'({cmp1, err1, to1, busy1}), 64'(0));
    @(negedge clk);
    iReset  = 1'b0;
    iSerial = 1'b1;
    tick(2, 1'b1);
    arm(1'b0);
    tick(1, 1'b1);
    sendFrame(F_CMD0, 1'b0, 1'b0, FW, 1'b1);
    endFrame();
    tick(3, 1'b1);

    // loopback of random frames with bench-computed CRC7
    @(negedge clk);
    iEnable = 1'b1;
    iSerial = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) tick(1, 1'b1);
      rnd = {$urandom(), $urandom()};
      hi  = {1'b0, rnd[38:0]};
      f   = {hi, crc7(hi), 1'b1};
      sendFrame(f, 1'b0, 1'b0, FW, 1'b1);
    end
    endFrame();
    tick(5, 1'b1);

    checkEq("dut1 pending events", 64'(q1.size()), 64'(0));
    checkEq("dut2 pending events", 64'(q2.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
